// File: rtl/rv32i_bus_pkg.sv
// Shared types for the RV32I core data bus and its APB bridge.
package rv32i_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
  } bus_req_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB3 request/response bundle with per-slave select lines.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic                  PENABLE;
  logic [NUM_SLAVES-1:0] PSEL;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PSTRB, PENABLE, PSEL,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/load_store_aligner.sv
// Byte-lane strobes, store replication, load extension and alignment check.
module load_store_aligner
  import rv32i_bus_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    strb       = 4'b0000;
    wdata_rep  = 32'h0;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    if (we) begin
      // Stores only define B/H/W; anything else is rejected before APB.
      case (func3)
        F3_B: begin
          strb      = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          misaligned = addr_lo[0];
          strb       = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_rep  = {2{wdata[15:0]}};
        end
        F3_W: begin
          misaligned = |addr_lo;
          strb       = 4'b1111;
          wdata_rep  = wdata;
        end
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_B:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
        F3_BU: rdata_ext = {24'h0, byte_sel};
        F3_H: begin
          misaligned = addr_lo[0];
          rdata_ext  = {{16{half_sel[15]}}, half_sel};
        end
        F3_HU: begin
          misaligned = addr_lo[0];
          rdata_ext  = {16'h0, half_sel};
        end
        F3_W: begin
          misaligned = |addr_lo;
          rdata_ext  = rdata;
        end
        default: misaligned = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/apb_master_bridge.sv
// RV32I data bus to APB3 bridge: decode, SETUP/ACCESS sequencing, timeout.
module apb_master_bridge
  import rv32i_bus_pkg::*;
#(
  parameter int          NUM_SLAVES      = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          SLAVE_SPAN_BITS = 12,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  busFunc3,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr,
  apb_master_bridge_if.master apb
);
  localparam int          IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [32:0] WIN_BYTES = 33'(NUM_SLAVES) << SLAVE_SPAN_BITS;
  localparam logic [7:0]  TO_LIM    = 8'(TIMEOUT_CYCLES);

  apb_state_e state, next_state;
  bus_req_t   req_q, req_d, req_c;
  logic [7:0] wait_cnt, wait_d;

  logic [NUM_SLAVES-1:0] psel_q, psel_d, psel_dec;
  logic                  penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]           paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d, err_q, err_d;

  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] idx;

  logic [3:0]  al_strb;
  logic [31:0] al_wdata, al_rdata;
  logic        al_mis;

  // Below-base addresses wrap to a huge offset and fall outside the window.
  assign offset = busAddr - BASE_ADDR;
  assign hit    = {1'b0, offset} < WIN_BYTES;
  assign idx    = IDX_W'(offset >> SLAVE_SPAN_BITS);

  for (genvar n = 0; n < NUM_SLAVES; n++) begin : g_dec
    assign psel_dec[n] = hit && (idx == IDX_W'(n));
  end

  // In IDLE the aligner sees the live request so the first APB cycle is registered in time.
  assign req_c = (state == IDLE) ? '{we: busWe, addr: busAddr, wdata: busWData, func3: busFunc3}
                                 : req_q;

  load_store_aligner u_align (
    .func3      (req_c.func3),
    .we         (req_c.we),
    .addr_lo    (req_c.addr[1:0]),
    .wdata      (req_c.wdata),
    .rdata      (apb.PRDATA),
    .strb       (al_strb),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (busReq) next_state = (!hit || al_mis) ? DONE : SETUP;
      SETUP:   next_state = ACCESS;
      // PREADY wins over a same-cycle timeout; both simply end the access.
      ACCESS:  if (apb.PREADY || wait_cnt == TO_LIM) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    wait_d    = wait_cnt;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = 32'h0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: if (busReq) begin
        req_d  = req_c;
        wait_d = 8'h0;
        if (next_state == SETUP) begin
          psel_d    = psel_dec;
          penable_d = 1'b0;
          paddr_d   = {busAddr[31:2], 2'b00};
          pwrite_d  = busWe;
          pwdata_d  = al_wdata;
          pstrb_d   = al_strb;
        end else begin
          ready_d = 1'b1;
          err_d   = 1'b1;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (next_state == DONE) begin
          psel_d    = '0;
          penable_d = 1'b0;
          paddr_d   = 32'h0;
          pwrite_d  = 1'b0;
          pwdata_d  = 32'h0;
          pstrb_d   = 4'h0;
          ready_d   = 1'b1;
          if (apb.PREADY) begin
            err_d   = apb.PSLVERR;
            rdata_d = apb.PSLVERR ? 32'h0 : al_rdata;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          wait_d = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        end
      end
      DONE:    wait_d = 8'h0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      wait_cnt  <= 8'h0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= 32'h0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0;
      pstrb_q   <= 4'h0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      req_q     <= req_d;
      wait_cnt  <= wait_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign busRData    = rdata_q;
  assign busReady    = ready_q;
  assign busErr      = err_q;
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Bridges the RV32I core's data bus (busWe/busAddr/busWData/busFunc3/busRData) onto an APB3-style peripheral bus with per-slave select. Sits directly downstream of the CPU, between the core and the memory-mapped peripherals. It handles:

- address decoding,
- the APB SETUP/ACCESS sequence with wait states,
- byte-lane strobes,
- load sign/zero extension, misalignment and timeout errors.

It returns a one-cycle `busReady` completion strobe that the core's load/store state waits on.

## Interface
- `NUM_SLAVES`, 4 — number of PSEL lines; slave n occupies `BASE_ADDR + n*2^SLAVE_SPAN_BITS`.
- `BASE_ADDR`, 32'h1000_0000 — base of the peripheral window.
- `SLAVE_SPAN_BITS`, 12 — log2 of bytes per slave window.
- `TIMEOUT_CYCLES`, 255 — maximum ACCESS cycles before abort, range 1..255.

Ports:
- `clk` input 1 — single clock. All logic is on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `busReq` input 1 — core requests a transfer. Held, along with the other bus inputs, until `busReady`.
- `busWe` input 1 — 1 = store, 0 = load.
- `busAddr` input 32 — byte address.
- `busWData` input 32 — store data, right-aligned.
- `busFunc3` input 3 — RV32I load/store funct3.
- `busRData` output 32 — extended load data. Valid only while `busReady`=1.
- `busReady` output 1 — one-cycle completion strobe.
- `busErr` output 1 — qualifies `busReady`: decode miss, misalignment, PSLVERR or timeout.
- `PADDR` output 32, `PWRITE` output 1, `PWDATA` output 32, `PSTRB` output 4, `PENABLE` output 1, `PSEL` output NUM_SLAVES — APB request signals.
- `PRDATA` input 32, `PREADY` input 1, `PSLVERR` input 1 — APB response from the selected slave, muxed externally.

## Operation
**FSM states:** IDLE, SETUP, ACCESS, DONE.

**IDLE, `busReq`=1:**
- Latch addr, wdata, func3, we, and the decoded slave index.
- Decode miss or misaligned → DONE with error; no APB activity.
- Otherwise → SETUP.

**Misalignment rules:**
- Halfword with addr[0]=1 is misaligned.
- Word with addr[1:0]≠0 is misaligned.
- Reserved funct3 (011, 110, 111; store 1xx) is misaligned.

**APB drive:**
- SETUP: one-hot PSEL=1, PENABLE=0 → ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1 → DONE. Capture PRDATA; set err = PSLVERR.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT_CYCLES → DONE with err=1 and rdata=0.
- DONE: `busReady`=1 and `busErr`=err for exactly one cycle → IDLE. `busReq` is not sampled in DONE.

**Address and strobes:**
- PADDR = {addr[31:2],2'b00}.
- PWRITE = we.
- Store strobes:
  - SB: PSTRB = 4'b0001<<addr[1:0], byte replicated on all four lanes.
  - SH: PSTRB = 4'b0011<<{addr[1],1'b0}, halfword replicated on both halves.
  - SW: PSTRB = 4'b1111.
- Loads: PSTRB=0 and PWDATA=0.

**Load extension:** select the lane by addr[1:0], then extend:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: pass through.
- Stores and error responses return `busRData`=0.

**Register and hold rules:**
- All APB outputs and `busRData`/`busReady`/`busErr` are registered.
- APB outputs are held stable from SETUP through the end of ACCESS. PSEL=0 outside SETUP/ACCESS.

## Timing
**Reset:**
- `rst`=1 at any edge, including mid-transfer: state=IDLE.
- All outputs are 0 from the next cycle: PSEL, PENABLE, PSTRB, PADDR, PWDATA, PWRITE, `busRData`, `busReady`, `busErr`.
- The wait counter clears.
- An aborted APB transfer is not retried.

**Latency:**
- Request sampled in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2. With PREADY=1, `busReady` is in cycle 3.
- Each PREADY=0 ACCESS cycle adds 1.
- Error without APB (miss or misaligned): `busReady` in cycle 1.
- Timeout: `busReady` at cycle 2+TIMEOUT_CYCLES+1. PSEL drops the cycle after the final ACCESS cycle.
- Back-to-back: a new request can be accepted in the cycle after DONE. Minimum spacing is 4 cycles per APB transfer.

**Boundaries:**
- Top address of the last slave decodes as a hit; `BASE_ADDR + NUM_SLAVES*span` is a miss.
- The wait counter is 8-bit and saturating. It never wraps before the timeout compare.
- PREADY=1 on the same cycle the counter hits TIMEOUT_CYCLES completes normally; PREADY takes priority.

## Structure
- **Shared package `rv32i_bus_pkg`:**
  - typedef `apb_state_e` {IDLE, SETUP, ACCESS, DONE}.
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- **Sub-module `load_store_aligner`** (combinational): computes PSTRB, replicated PWDATA, extended load data and the misaligned flag from func3, addr[1:0], wdata and rdata. The bridge FSM, decoder, counter and registers live in `apb_master_bridge`.

## Test plan
- **SW, zero wait:** reset, then SW addr 0x1000_1004, data 0xDEADBEEF, PREADY=1 → PSEL=4'b0010 in cycles 1–2, PENABLE in cycle 2, PADDR=0x1000_1004, PSTRB=1111, `busReady`=1 and `busErr`=0 in cycle 3.
- **LB/LBU extension:** LB addr 0x1000_0003 with PRDATA 0x80AA_5511 → `busRData`=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- **SH with wait states:** SH addr 0x1000_2002, data 0x0000_1234, PREADY low 3 cycles → PSTRB=1100, PWDATA=0x1234_1234, `busReady` in cycle 6, outputs stable throughout ACCESS.
- **Errors:**
  - LW addr 0x1000_0002 → `busReady`=`busErr`=1 in cycle 1, PSEL never asserted.
  - addr 0x2000_0000 → same response.
  - PSLVERR=1 with PREADY=1 → `busErr`=1.
- **Timeout:** TIMEOUT_CYCLES=4, PREADY held 0 → `busReady`=`busErr`=1 in cycle 7, `busRData`=0, PSEL=0 from cycle 7.
- **Reset mid-operation:** assert `rst` during ACCESS → PSEL, PENABLE, `busReady` all 0 the next cycle. A following LW completes normally.
